// File: rtl/coin_acceptor_pkg.sv
// coin_acceptor_pkg
//   Shared definitions for the coin front end and the downstream vending FSM:
//   acceptor state encodings (visible on the astate debug port) and the
//   coin-type constants held in the coin-type register.
package coin_acceptor_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_DEBOUNCE = 3'd1,
        ST_ACCEPT   = 3'd2,
        ST_REJECT   = 3'd3,
        ST_WAIT_REL = 3'd4
    } astate_t;

    localparam logic COIN_1 = 1'b0;
    localparam logic COIN_5 = 1'b1;

endpackage

// File: rtl/coin_acceptor_sync_2ff.sv
// sync_2ff
//   1-bit two-flop synchroniser with asynchronous active-low clear.
//   Ports:
//     clk    in  1  destination clock, rising edge
//     rst_n  in  1  asynchronous clear, active-low (both flops to 0)
//     d      in  1  asynchronous input
//     q      out 1  synchronised output, two clocks of latency
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/coin_acceptor.sv
// coin_acceptor
//   Front end for the vending FSM. Synchronises and debounces the raw 1-peso
//   and 5-peso slot sensors and emits exactly one single-cycle p1/p5 pulse per
//   accepted coin, or a reject pulse on simultaneous coins / when the FSM is
//   not accepting. Outputs are decoded from registers only.
//   Ports:
//     clk        in  1  system clock, rising edge
//     rst        in  1  asynchronous reset, active-low
//     coin1_raw  in  1  raw 1-peso sensor, async, high = coin present
//     coin5_raw  in  1  raw 5-peso sensor, async, high = coin present
//     accept_en  in  1  high = downstream FSM can take a coin
//     p1         out 1  one-cycle pulse, 1-peso coin accepted
//     p5         out 1  one-cycle pulse, 5-peso coin accepted
//     reject     out 1  one-cycle pulse, coin returned
//     astate     out 3  current state encoding (debug)
module coin_acceptor
    import coin_acceptor_pkg::*;
#(
    parameter int unsigned DB_CYCLES = 4,
    parameter int unsigned CNT_W     = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       coin1_raw,
    input  logic       coin5_raw,
    input  logic       accept_en,
    output logic       p1,
    output logic       p5,
    output logic       reject,
    output logic [2:0] astate
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    logic             s1, s5;
    astate_t          state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic             coin_type, coin_type_nx;
    logic             lat_line, oth_line;

    sync_2ff u_sync1 (.clk(clk), .rst_n(rst), .d(coin1_raw), .q(s1));
    sync_2ff u_sync5 (.clk(clk), .rst_n(rst), .d(coin5_raw), .q(s5));

    // Line of the latched coin type and the opposite line, used while debouncing.
    assign lat_line = (coin_type == COIN_5) ? s5 : s1;
    assign oth_line = (coin_type == COIN_5) ? s1 : s5;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            coin_type <= COIN_1;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            coin_type <= coin_type_nx;
        end
    end

    // Next-state logic
    always_comb begin
        state_nx     = state;
        cnt_nx       = cnt;
        coin_type_nx = coin_type;
        case (state)
            ST_IDLE: begin
                if (s1 && s5) begin
                    state_nx = ST_REJECT;
                end else if (s1 || s5) begin
                    state_nx     = ST_DEBOUNCE;
                    coin_type_nx = s5 ? COIN_5 : COIN_1;
                    cnt_nx       = '0;
                end
            end
            ST_DEBOUNCE: begin
                if (!lat_line) begin
                    state_nx = ST_IDLE;
                end else if (oth_line) begin
                    state_nx = ST_REJECT;
                end else if (cnt == CNT_LAST) begin
                    // accept_en only matters on this decision edge
                    state_nx = accept_en ? ST_ACCEPT : ST_REJECT;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            ST_ACCEPT, ST_REJECT: begin
                state_nx = ST_WAIT_REL;
                cnt_nx   = '0;
            end
            ST_WAIT_REL: begin
                if (s1 || s5) begin
                    cnt_nx = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nx = ST_IDLE;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            default: begin
                state_nx = ST_IDLE;
                cnt_nx   = '0;
            end
        endcase
    end

    // Output decode (registers only)
    always_comb begin
        p1     = 1'b0;
        p5     = 1'b0;
        reject = 1'b0;
        astate = state;
        case (state)
            ST_ACCEPT: begin
                p1 = (coin_type == COIN_1);
                p5 = (coin_type == COIN_5);
            end
            ST_REJECT: reject = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_coin_acceptor.sv
module tb_coin_acceptor;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       coin1_raw = 1'b0;
    logic       coin5_raw = 1'b0;
    logic       accept_en = 1'b1;
    logic       p1, p5, reject;
    logic [2:0] astate;

    int errors = 0;
    int checks = 0;
    int n_p1 = 0, n_p5 = 0, n_rej = 0, n_multi = 0;
    int b_p1, b_p5, b_rej;

    coin_acceptor #(.DB_CYCLES(4), .CNT_W(3)) dut (
        .clk(clk), .rst(rst), .coin1_raw(coin1_raw), .coin5_raw(coin5_raw),
        .accept_en(accept_en), .p1(p1), .p5(p5), .reject(reject), .astate(astate)
    );

    always #10 clk = ~clk;

    // Pulse tally, sampled mid-cycle
    always @(negedge clk) begin
        if (p1) n_p1++;
        if (p5) n_p5++;
        if (reject) n_rej++;
        if ((int'(p1) + int'(p5) + int'(reject)) > 1) n_multi++;
    end

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic snap();
        b_p1 = n_p1; b_p5 = n_p5; b_rej = n_rej;
    endtask

    initial begin
        // 1. reset held with toggling coin lines
        #1;
        chk("rst_astate_t0", astate, 0);
        chk("rst_out_t0", {p1, p5, reject}, 0);
        for (int i = 0; i < 4; i++) begin
            coin1_raw = ~coin1_raw;
            coin5_raw = (i % 2) == 0;
            #10;
            chk("rst_astate", astate, 0);
            chk("rst_out", {p1, p5, reject}, 0);
        end
        coin1_raw = 1'b0; coin5_raw = 1'b0;
        @(negedge clk); rst = 1'b1;
        tick(3);
        chk("idle_after_rst", astate, 0);

        // 2. 1-peso coin held 40 cycles, accept_en=1
        snap();
        coin1_raw = 1'b1;                    // first sampled at edge E
        tick(1); chk("t2_E", astate, 0);
        tick(1); chk("t2_E1", astate, 0);
        tick(1); chk("t2_E2_deb", astate, 1);
        tick(3); chk("t2_E5_deb", astate, 1);
        chk("t2_no_early_p1", n_p1 - b_p1, 0);
        tick(1); chk("t2_E6_acc", astate, 2);
        chk("t2_p1_hi", p1, 1);
        chk("t2_p5_lo", p5, 0);
        tick(1); chk("t2_E7_wait", astate, 4);
        chk("t2_p1_1cyc", p1, 0);
        tick(32);                            // edges E+8..E+39
        chk("t2_held_wait", astate, 4);
        coin1_raw = 1'b0;                    // release sampled at R
        tick(5); chk("t2_R4_wait", astate, 4);
        tick(1); chk("t2_R5_idle", astate, 0);
        chk("t2_p1_count", n_p1 - b_p1, 1);
        chk("t2_p5_count", n_p5 - b_p5, 0);
        chk("t2_rej_count", n_rej - b_rej, 0);
        tick(2);

        // 3. 5-peso glitch, 2 cycles
        snap();
        coin5_raw = 1'b1;
        tick(2);
        coin5_raw = 1'b0;
        tick(1); chk("t3_E2_deb", astate, 1);
        tick(1); chk("t3_E3_deb", astate, 1);
        tick(1); chk("t3_E4_idle", astate, 0);
        tick(6);
        chk("t3_p5_count", n_p5 - b_p5, 0);
        chk("t3_rej_count", n_rej - b_rej, 0);

        // 4. simultaneous coins
        snap();
        coin1_raw = 1'b1; coin5_raw = 1'b1;
        tick(2); chk("t4_E1_idle", astate, 0);
        tick(1); chk("t4_E2_rej", astate, 3);
        chk("t4_reject_hi", reject, 1);
        tick(1); chk("t4_E3_wait", astate, 4);
        chk("t4_reject_lo", reject, 0);
        tick(4);
        coin1_raw = 1'b0; coin5_raw = 1'b0;
        tick(8); chk("t4_back_idle", astate, 0);
        chk("t4_rej_count", n_rej - b_rej, 1);
        chk("t4_p_count", (n_p1 - b_p1) + (n_p5 - b_p5), 0);

        // 5a. accept_en=0, 5-peso coin 20 cycles
        snap();
        accept_en = 1'b0;
        coin5_raw = 1'b1;
        tick(6); chk("t5a_E5_deb", astate, 1);
        tick(1); chk("t5a_E6_rej", astate, 3);
        chk("t5a_reject_hi", reject, 1);
        chk("t5a_p5_lo", p5, 0);
        tick(13);
        coin5_raw = 1'b0;
        tick(8); chk("t5a_idle", astate, 0);
        chk("t5a_rej_count", n_rej - b_rej, 1);
        chk("t5a_p5_count", n_p5 - b_p5, 0);

        // 5b. same with accept_en=1
        snap();
        accept_en = 1'b1;
        coin5_raw = 1'b1;
        tick(7); chk("t5b_E6_acc", astate, 2);
        chk("t5b_p5_hi", p5, 1);
        chk("t5b_p1_lo", p1, 0);
        tick(13);
        coin5_raw = 1'b0;
        tick(8); chk("t5b_idle", astate, 0);
        chk("t5b_p5_count", n_p5 - b_p5, 1);
        chk("t5b_rej_count", n_rej - b_rej, 0);

        // 6. reset during DEBOUNCE with coin held through release
        snap();
        coin1_raw = 1'b1;
        tick(4); chk("t6_deb", astate, 1);
        #5 rst = 1'b0;
        #1 chk("t6_async_astate", astate, 0);
        chk("t6_async_out", {p1, p5, reject}, 0);
        tick(2);
        chk("t6_in_rst", astate, 0);
        @(negedge clk); rst = 1'b1;
        chk("t6_no_pulse_in_rst", n_p1 - b_p1, 0);
        tick(20);
        chk("t6_held_wait", astate, 4);
        coin1_raw = 1'b0;
        tick(8); chk("t6_idle", astate, 0);
        chk("t6_p1_count", n_p1 - b_p1, 1);
        chk("t6_rej_count", n_rej - b_rej, 0);

        chk("mutex_outputs", n_multi, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
